des_block_sequencer: RTL and testbench

//  Sequential front/back end for the combinational DES core (DES: enc1_dec0, in, key, out; [1:64] bit order).

---
 rtl/des_pkg.sv | 41 ++++
 rtl/DES.sv | 59 +++++
 rtl/des_block_sequencer.sv | 144 ++++++++++++++
 tb/tb_des_block_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared block width, sequencer state encoding and the DES permutation/S-box tables.
package des_pkg;
  localparam int DES_BLK_W = 64;
  typedef logic [1:DES_BLK_W] des_blk_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_RUN = ST_RUN, S_OUT = ST_OUT} state_e;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int PERM_P [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  // rounds 1, 2, 9 and 16 rotate the key halves by one, all others by two
  localparam logic [1:16] SHIFT2 = 16'b0011111101111110;
  // each S-box is 64 nibbles, row-major (row = outer bits, col = inner four bits)
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
  function automatic int ip_src(input int i);
    return (i / 8 < 4) ? 58 + 2 * (i / 8) - 8 * (i % 8) : 57 + 2 * (i / 8 - 4) - 8 * (i % 8);
  endfunction
endpackage

// File: rtl/DES.sv
// DES: combinational DES core in [1:64] bit order; enc1_dec0 selects the subkey order.
module DES
  import des_pkg::*;
(
  input  logic        enc1_dec0,
  input  logic [1:64] in,
  input  logic [1:64] key,
  output logic [1:64] out
);
  function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s;
    logic [1:32] p;
    logic [5:0] six;
    logic [5:0] idx;
    for (int i = 0; i < 48; i++) x[i+1] = r[(4 * (i / 6) + i % 6 + 31) % 32 + 1] ^ k[i+1];
    for (int b = 0; b < 8; b++) begin
      six = x[6*b+1 +: 6];
      idx = {six[5], six[0], six[4:1]};
      s[4*b+1 +: 4] = SBOX[b][255 - 4 * int'(idx) -: 4];
    end
    for (int i = 0; i < 32; i++) p[i+1] = s[PERM_P[i]];
    return p;
  endfunction

  function automatic logic [1:64] crypt(input logic enc, input logic [1:64] blk, input logic [1:64] k);
    logic [1:56] cd;
    logic [1:28] c;
    logic [1:28] d;
    logic [1:48] ks [16];
    logic [1:64] x;
    logic [1:64] y;
    logic [1:32] l;
    logic [1:32] r;
    logic [1:32] t;
    for (int i = 0; i < 56; i++) cd[i+1] = k[PC1[i]];
    c = cd[1:28];
    d = cd[29:56];
    for (int n = 1; n <= 16; n++) begin
      c = SHIFT2[n] ? {c[3:28], c[1:2]} : {c[2:28], c[1]};
      d = SHIFT2[n] ? {d[3:28], d[1:2]} : {d[2:28], d[1]};
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n-1][i+1] = cd[PC2[i]];
    end
    for (int i = 0; i < 64; i++) x[i+1] = blk[ip_src(i)];
    l = x[1:32];
    r = x[33:64];
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ feistel(r, enc ? ks[n] : ks[15-n]);
      l = t;
    end
    x = {r, l};
    for (int i = 0; i < 64; i++) y[ip_src(i)] = x[i+1];
    return y;
  endfunction

  assign out = crypt(enc1_dec0, in, key);
endmodule

// File: rtl/des_block_sequencer.sv
// des_block_sequencer: valid/ready block sequencer that drives the combinational DES core.
// Define DES_CBC_EN to wrap the core in CBC chaining; the default build is ECB.
module des_block_sequencer
  import des_pkg::*;
#(
  parameter int unsigned CORE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_load_i,
  input  logic        cfg_enc1_dec0_i,
  input  logic [1:64] cfg_key_i,
  input  logic [1:64] cfg_iv_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:64] in_data_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [1:64] out_data_o,
  output logic        out_last_o,
  output logic        busy_o
);
  localparam logic [3:0] CNT_INIT = 4'(CORE_WAIT - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  des_blk_t blk_q, blk_d, key_q, key_d, out_data_q, out_data_d;
  des_blk_t core_in, core_out, result;
  logic last_q, last_d, enc_q, enc_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;

`ifdef DES_CBC_EN
  des_blk_t iv_q, iv_d, chain_q, chain_d;
  assign core_in = enc_q ? blk_q ^ chain_q : blk_q;
  assign result  = enc_q ? core_out : core_out ^ chain_q;
`else
  logic unused_iv;
  assign unused_iv = ^cfg_iv_i;
  assign core_in   = blk_q;
  assign result    = core_out;
`endif

  // the core is a multicycle path: its inputs are held in registers for CORE_WAIT cycles
  DES u_des (
    .enc1_dec0 (enc_q),
    .in        (core_in),
    .key       (key_q),
    .out       (core_out)
  );

  assign in_ready_o  = state_q == S_IDLE;
  assign busy_o      = state_q != S_IDLE;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    last_d      = last_q;
    key_d       = key_q;
    enc_d       = enc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef DES_CBC_EN
    iv_d        = iv_q;
    chain_d     = chain_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_load_i) begin
          enc_d   = cfg_enc1_dec0_i;
          key_d   = cfg_key_i;
`ifdef DES_CBC_EN
          iv_d    = cfg_iv_i;
          chain_d = cfg_iv_i;
`endif
        end
        if (in_valid_i) begin
          blk_d   = in_data_i;
          last_d  = in_last_i;
          cnt_d   = CNT_INIT;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_data_d  = result;
          out_last_d  = last_q;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef DES_CBC_EN
          // a finished message restarts the chain at the IV
          chain_d     = out_last_q ? iv_q : (enc_q ? out_data_q : blk_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      blk_q       <= '0;
      last_q      <= 1'b0;
      key_q       <= '0;
      enc_q       <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef DES_CBC_EN
      iv_q        <= '0;
      chain_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      last_q      <= last_d;
      key_q       <= key_d;
      enc_q       <= enc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef DES_CBC_EN
      iv_q        <= iv_d;
      chain_q     <= chain_d;
`endif
    end
  end
endmodule

// File: tb/tb_des_block_sequencer.sv
// tb_des_block_sequencer: directed self-checking bench for des_block_sequencer (CBC tests need DES_CBC_EN).
module tb_des_block_sequencer;
  localparam int CW = 2;
  localparam logic [1:64] K   = 64'h22234512987ABB23;
  localparam logic [1:64] PT  = 64'h0000000000000001;
  localparam logic [1:64] CT  = 64'h0A4ED5C15A63FEA3;
  localparam logic [1:64] CT2 = 64'h0A4ED5C15A63FEA2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_load = 1'b0, cfg_enc = 1'b1;
  logic [1:64] cfg_key = '0, cfg_iv = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [1:64] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [1:64] out_data;
  int checks = 0;
  int errors = 0;

  des_block_sequencer #(.CORE_WAIT(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_load_i      (cfg_load),
    .cfg_enc1_dec0_i (cfg_enc),
    .cfg_key_i       (cfg_key),
    .cfg_iv_i        (cfg_iv),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .in_last_i       (in_last),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_data_o      (out_data),
    .out_last_o      (out_last),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic enc, input logic [1:64] key, input logic [1:64] iv);
    cfg_load = 1'b1; cfg_enc = enc; cfg_key = key; cfg_iv = iv;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [1:64] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic accept;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b expected 0", out_valid); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", out_last); end
  endtask

  task automatic test_ecb_enc;
    int n;
    load(1'b1, K, '0);
    send(PT, 1'b0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL enc_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc_early_valid: got %b expected 0", out_valid); end
    wait_out(n);
    checks++; if (n !== CW) begin errors++; $display("FAIL enc_latency: got %0d expected %0d", n, CW); end
    checks++; if (out_data !== CT) begin errors++; $display("FAIL enc_data: got %h expected %h", out_data, CT); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL enc_last: got %b expected 0", out_last); end
    accept();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL enc_done: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_ecb_dec;
    int n;
    load(1'b0, K, '0);
    send(CT, 1'b1);
    wait_out(n);
    checks++; if (out_data !== PT) begin errors++; $display("FAIL dec_data: got %h expected %h", out_data, PT); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL dec_last: got %b expected 1", out_last); end
    accept();
  endtask

  task automatic test_backpressure;
    int n;
    load(1'b1, K, '0);
    send(PT, 1'b1);
    wait_out(n);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
      checks++; if (out_data !== CT) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", c, out_data, CT); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
    end
    accept();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b busy=%b out_valid=%b expected 1/0/0", in_ready, busy, out_valid); end
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int second = -1;
    load(1'b1, K, '0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = PT; in_last = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (in_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (second - first !== CW + 2) begin errors++; $display("FAIL b2b_period: got %0d expected %0d", second - first, CW + 2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_cfg_coincident;
    int n;
    load(1'b0, K, '0);
    cfg_load = 1'b1; cfg_enc = 1'b1; cfg_key = K;
    in_valid = 1'b1; in_data = PT; in_last = 1'b1;
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    wait_out(n);
    checks++; if (out_data !== CT) begin errors++; $display("FAIL coinc_data: got %h expected %h", out_data, CT); end
    accept();
  endtask

  task automatic test_cfg_during_run;
    int n;
    load(1'b1, K, '0);
    send(PT, 1'b1);
    cfg_load = 1'b1; cfg_enc = 1'b0; cfg_key = 64'h0123456789ABCDEF;
    tick();
    cfg_load = 1'b0;
    wait_out(n);
    checks++; if (out_data !== CT) begin errors++; $display("FAIL run_load_data: got %h expected %h", out_data, CT); end
    accept();
    send(PT, 1'b1);
    wait_out(n);
    checks++; if (out_data !== CT) begin errors++; $display("FAIL run_load_kept: got %h expected %h", out_data, CT); end
    accept();
    load(1'b0, K, '0);
    send(CT, 1'b1);
    wait_out(n);
    checks++; if (out_data !== PT) begin errors++; $display("FAIL idle_load_data: got %h expected %h", out_data, PT); end
    accept();
  endtask

  task automatic test_reset_mid;
    int n;
    load(1'b1, K, '0);
    send(PT, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async: got busy=%b out_valid=%b expected 0/0", busy, out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rstmid_data_async: got %h expected 0", out_data); end
    #2 rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
    load(1'b1, K, '0);
    send(PT, 1'b1);
    wait_out(n);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstout_pre: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstout_async: got %b expected 0", out_valid); end
    #2 rst_n = 1'b1;
    tick();
  endtask

`ifdef DES_CBC_EN
  task automatic test_cbc;
    int n;
    load(1'b1, K, 64'h1);
    send(64'h0, 1'b0);
    wait_out(n);
    checks++; if (out_data !== CT) begin errors++; $display("FAIL cbc_enc0: got %h expected %h", out_data, CT); end
    accept();
    send(CT2, 1'b1);
    wait_out(n);
    checks++; if (out_data !== CT) begin errors++; $display("FAIL cbc_enc1: got %h expected %h", out_data, CT); end
    accept();
    send(64'h0, 1'b1);
    wait_out(n);
    checks++; if (out_data !== CT) begin errors++; $display("FAIL cbc_restart: got %h expected %h", out_data, CT); end
    accept();
    load(1'b0, K, 64'h1);
    send(CT, 1'b0);
    wait_out(n);
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL cbc_dec0: got %h expected 0", out_data); end
    accept();
    send(CT, 1'b1);
    wait_out(n);
    checks++; if (out_data !== CT2) begin errors++; $display("FAIL cbc_dec1: got %h expected %h", out_data, CT2); end
    accept();
  endtask
`endif

  initial begin
    test_reset();
    test_ecb_enc();
    test_ecb_dec();
    test_backpressure();
    test_back_to_back();
    test_cfg_coincident();
    test_cfg_during_run();
`ifdef DES_CBC_EN
    test_cbc();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
